addr_cmd_slot_mem: RTL

ADDR_CMD_SLOT_MEM -- requirements
Module: addr_cmd_slot_mem

---
 rtl/addr_cmd_slot_mem.sv | 133 +++++++++++++
 1 files changed

// File: rtl/addr_cmd_slot_mem.sv
// Slot memory with byte-enabled host access, per-slot valid bits and a
// round-robin encoder fetch that returns the next valid slot after the last one served.
module addr_cmd_slot_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [DATA_W/8-1:0] host_be,
  input  logic              host_wr,
  input  logic              host_rd,
  input  logic              host_inval,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvld,
  input  logic              enc_req,
  output logic              enc_ack,
  output logic [DATA_W-1:0] enc_data,
  output logic [ADDR_W-1:0] enc_slot,
  output logic              enc_none,
  output logic [ADDR_W:0]   valid_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;
  localparam int CW    = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, SCAN, ACK} enc_state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [DATA_W-1:0] host_merged;

  enc_state_t        state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next, cnt, cnt_next, last_slot;
  logic              load_hit, load_none;
  logic              probe_wr, probe_valid;
  logic [DATA_W-1:0] probe_data;
  logic              cnt_inc, cnt_dec;

  // Word as it will look after this cycle's host write; feeds both read paths.
  always_comb begin
    host_merged = mem[host_addr];
    for (int i = 0; i < NB; i++)
      if (host_wr && host_be[i]) host_merged[i*8 +: 8] = host_wdata[i*8 +: 8];
  end

  // NOTE: storage has no reset; only the valid bits define slot state.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (host_wr && host_be[i]) mem[host_addr][i*8 +: 8] <= host_wdata[i*8 +: 8];
  end

  assign cnt_inc = host_wr && !valid[host_addr];
  assign cnt_dec = !host_wr && host_inval && valid[host_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid      <= '0;
      valid_cnt  <= '0;
      host_rvld  <= 1'b0;
      host_rdata <= '0;
    end else begin
      if (host_wr)         valid[host_addr] <= 1'b1;
      else if (host_inval) valid[host_addr] <= 1'b0;
      valid_cnt <= valid_cnt + CW'(cnt_inc) - CW'(cnt_dec);
      host_rvld <= host_rd;
      if (host_rd) host_rdata <= host_merged;
    end
  end

  // Write-first probe: a host write landing on the probed slot is seen immediately.
  assign probe_wr    = host_wr && (host_addr == ptr);
  assign probe_valid = valid[ptr] || probe_wr;
  assign probe_data  = probe_wr ? host_merged : mem[ptr];

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    cnt_next   = cnt;
    load_hit   = 1'b0;
    load_none  = 1'b0;
    unique case (state)
      IDLE: if (enc_req) begin
        state_next = SCAN;
        ptr_next   = last_slot + ADDR_W'(1);
        cnt_next   = '0;
      end
      SCAN: if (probe_valid) begin
        state_next = ACK;
        load_hit   = 1'b1;
      end else if (&cnt) begin
        state_next = ACK;
        load_none  = 1'b1;
      end else begin
        ptr_next = ptr + ADDR_W'(1);
        cnt_next = cnt + ADDR_W'(1);
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enc_ack = (state == ACK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      last_slot <= '1;
      enc_data  <= '0;
      enc_slot  <= '0;
      enc_none  <= 1'b0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      cnt   <= cnt_next;
      if (state == ACK && !enc_none) last_slot <= enc_slot;
      if (load_hit) begin
        enc_data <= probe_data;
        enc_slot <= ptr;
        enc_none <= 1'b0;
      end else if (load_none) begin
        enc_data <= '0;
        enc_slot <= '0;
        enc_none <= 1'b1;
      end
    end
  end

endmodule
